multicycle_controller: RTL and testbench

Control unit for the multicycle ARMv4 core. It sequences the shared datapath (the single memory port, ALU, immediate extender and register file) over 3-5 cycles per instruction. It holds the NZCV flags and evaluates condition codes. ImmSrc drives the extender select, so 00 selects imm8, 01 selects imm12 and 10 selects branch offset.

---
 rtl/multicycle_controller.sv | 174 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 123 ++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle ARMv4 control unit: sequences fetch/decode/execute over the
// shared datapath, holds NZCV and gates writes on the condition outcome.
module multicycle_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic [1:0]   ResultSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_e;

  // Raw per-state controls, before condition/reset gating.
  typedef struct packed {
    logic       next_pc;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.ir_write = 1'b1; c.next_pc = 1'b1; c.alu_src_a = 1'b1;
                    c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      DECODE: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      MEMADR: c.alu_src_b = 2'b01;
      MEMRD:  c.adr_src = 1'b1;
      MEMWB:  begin c.result_src = 2'b01; c.reg_w = 1'b1; end
      MEMWR:  begin c.adr_src = 1'b1; c.mem_w = 1'b1; end
      EXECR:  c.alu_op = 1'b1;
      EXECI:  begin c.alu_src_b = 2'b01; c.alu_op = 1'b1; end
      ALUWB:  c.reg_w = 1'b1;
      BRANCH: begin c.alu_src_b = 2'b01; c.result_src = 2'b10; c.branch = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  state_e     state_q, state_d;
  ctrl_t      ctrl_q;
  logic [3:0] flags_q;
  logic       condex_q;

  logic [1:0] op;
  logic [3:0] cmd, cond, rd;
  logic [1:0] flag_w;
  logic       s_eff, no_write, cond_ex, pcs;
  logic       n, z, c, v;
  logic       unused_rn;

  assign op        = Instr[27:26];
  assign cmd       = Instr[24:21];
  assign cond      = Instr[31:28];
  assign rd        = Instr[15:12];
  assign unused_rn = ^Instr[19:16];
  assign {n, z, c, v} = flags_q;

  // Next-state sequencing; DECODE branches on the instruction class.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: case (op)
                2'b01:   state_d = MEMADR;
                2'b00:   state_d = Instr[25] ? EXECI : EXECR;
                2'b10:   state_d = BRANCH;
                default: state_d = FETCH;
              endcase
      MEMADR: state_d = Instr[20] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR, EXECI: state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  // ALU decode and flag-write enables; only meaningful in the execute states.
  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    s_eff      = Instr[20];
    if (ctrl_q.alu_op) begin
      case (cmd)
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        4'b1010: begin ALUControl = 2'b01; s_eff = 1'b1; end
        default: ALUControl = 2'b00;
      endcase
      flag_w[1] = s_eff;
      flag_w[0] = s_eff & ~ALUControl[1];
    end
  end

  // CMP suppresses writeback; taken from the instruction rather than ALUOp
  // because the write happens in ALUWB, after the execute state.
  assign no_write = (op == 2'b00) && (cmd == 4'b1010);

  // Condition-code evaluation against the held flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0: cond_ex = z;
      4'h1: cond_ex = ~z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = ~c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = ~n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = ~v;
      4'h8: cond_ex = c & ~z;
      4'h9: cond_ex = ~c | z;
      4'hA: cond_ex = (n == v);
      4'hB: cond_ex = (n != v);
      4'hC: cond_ex = ~z & (n == v);
      4'hD: cond_ex = z | (n != v);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // State, registered controls (for the state being entered), flags, CondEx.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      ctrl_q   <= ctrl_of(FETCH);
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
      if (state_q == DECODE) condex_q <= cond_ex;
      if ((state_q == EXECR || state_q == EXECI) && condex_q) begin
        if (flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Write enables are masked by reset so an abort never glitches a write.
  assign pcs      = ctrl_q.branch | (ctrl_q.reg_w & (rd == 4'hF));
  assign PCWrite  = reset & (ctrl_q.next_pc | (pcs & condex_q));
  assign RegWrite = reset & ctrl_q.reg_w & condex_q & ~no_write;
  assign MemWrite = reset & ctrl_q.mem_w & condex_q;
  assign IRWrite  = reset & ctrl_q.ir_write;

  assign AdrSrc    = ctrl_q.adr_src;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ImmSrc    = op;
  assign RegSrc    = {(op == 2'b01) & ~Instr[20], (op == 2'b10)};

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; expected control vectors are
// queued when stimulus is applied and compared when outputs are sampled.
module tb_multicycle_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]   ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;
  exp_t sb[$];

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  // Vector layout: pcw mw rw irw adr res[2] srcA srcB[2] imm[2] regsrc[2] aluctl[2]
  task automatic chk(input string tag, input logic [15:0] e);
    exp_t x;
    logic [15:0] obs;
    sb.push_back('{tag, e});
    #1;
    obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, RegSrc, ALUControl};
    x = sb.pop_front();
    checks++;
    assert (obs === x.v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.v);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; Instr = 20'hE0821; ALUFlags = 4'hF;
    // reset held: FETCH selects, every enable low
    nxt(); chk("rst0", 16'b0_0_0_0_0_10_1_10_00_00_00);
    nxt(); chk("rst1", 16'b0_0_0_0_0_10_1_10_00_00_00);
    nxt(); chk("rst2", 16'b0_0_0_0_0_10_1_10_00_00_00);
    reset = 1'b1;
    // ADD R1,R2,R3 (S=0, so flags must stay clear despite ALUFlags=F)
    chk("add_fetch", 16'b1_0_0_1_0_10_1_10_00_00_00);
    nxt(); chk("add_dec",   16'b0_0_0_0_0_10_1_10_00_00_00);
    nxt(); chk("add_execr", 16'b0_0_0_0_0_00_0_00_00_00_00);
    nxt(); chk("add_aluwb", 16'b0_0_1_0_0_00_0_00_00_00_00);
    // LDR R1,[R2,#4]
    nxt(); Instr = 20'hE5921;
    chk("ldr_fetch", 16'b1_0_0_1_0_10_1_10_01_00_00);
    nxt(); chk("ldr_dec",    16'b0_0_0_0_0_10_1_10_01_00_00);
    nxt(); chk("ldr_memadr", 16'b0_0_0_0_0_00_0_01_01_00_00);
    nxt(); chk("ldr_memrd",  16'b0_0_0_0_1_00_0_00_01_00_00);
    nxt(); chk("ldr_memwb",  16'b0_0_1_0_0_01_0_00_01_00_00);
    // STR
    nxt(); Instr = 20'hE5821;
    chk("str_fetch", 16'b1_0_0_1_0_10_1_10_01_10_00);
    nxt(); chk("str_dec",    16'b0_0_0_0_0_10_1_10_01_10_00);
    nxt(); chk("str_memadr", 16'b0_0_0_0_0_00_0_01_01_10_00);
    nxt(); chk("str_memwr",  16'b0_1_0_0_1_00_0_00_01_10_00);
    // SUBS R0,R0,R0 producing Z
    nxt(); Instr = 20'hE0500;
    chk("subs_fetch", 16'b1_0_0_1_0_10_1_10_00_00_00);
    nxt(); chk("subs_dec", 16'b0_0_0_0_0_10_1_10_00_00_00);
    nxt(); ALUFlags = 4'b0100;
    chk("subs_execr", 16'b0_0_0_0_0_00_0_00_00_00_01);
    nxt(); ALUFlags = 4'hF;
    chk("subs_aluwb", 16'b0_0_1_0_0_00_0_00_00_00_00);
    // BEQ taken
    nxt(); Instr = 20'h0A000;
    chk("beq1_fetch", 16'b1_0_0_1_0_10_1_10_10_01_00);
    nxt(); chk("beq1_dec",    16'b0_0_0_0_0_10_1_10_10_01_00);
    nxt(); chk("beq1_branch", 16'b1_0_0_0_0_10_0_01_10_01_00);
    // CMP R0,R0 clearing flags; no register write
    nxt(); Instr = 20'hE1500;
    chk("cmp_fetch", 16'b1_0_0_1_0_10_1_10_00_00_00);
    nxt(); chk("cmp_dec", 16'b0_0_0_0_0_10_1_10_00_00_00);
    nxt(); ALUFlags = 4'b0000;
    chk("cmp_execr", 16'b0_0_0_0_0_00_0_00_00_00_01);
    nxt(); ALUFlags = 4'hF;
    chk("cmp_aluwb", 16'b0_0_0_0_0_00_0_00_00_00_00);
    // BEQ not taken, BNE taken
    nxt(); Instr = 20'h0A000;
    nxt(); nxt(); chk("beq2_branch", 16'b0_0_0_0_0_10_0_01_10_01_00);
    nxt(); Instr = 20'h1A000;
    nxt(); nxt(); chk("bne_branch",  16'b1_0_0_0_0_10_0_01_10_01_00);
    // SUBS again to set Z, then STR aborted by reset in MEMWR
    nxt(); Instr = 20'hE0500;
    nxt(); nxt(); ALUFlags = 4'b0100;
    nxt(); ALUFlags = 4'hF;
    nxt(); Instr = 20'hE5821;
    nxt(); nxt();
    nxt(); chk("str2_memwr", 16'b0_1_0_0_1_00_0_00_01_10_00);
    reset = 1'b0;
    chk("abort", 16'b0_0_0_0_0_10_1_10_01_10_00);
    nxt(); chk("abort_hold", 16'b0_0_0_0_0_10_1_10_01_10_00);
    reset = 1'b1; Instr = 20'h0A000;
    // flags cleared by reset, so BEQ must fall through
    chk("post_fetch", 16'b1_0_0_1_0_10_1_10_10_01_00);
    nxt(); chk("post_dec",    16'b0_0_0_0_0_10_1_10_10_01_00);
    nxt(); chk("post_branch", 16'b0_0_0_0_0_10_0_01_10_01_00);
    nxt(); Instr = 20'hE0821;
    chk("post_refetch", 16'b1_0_0_1_0_10_1_10_00_00_00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
